// File: rtl/regs_pkg.sv
// regs_pkg: shared types and constants for the regs write-port arbiter
package regs_pkg;
  typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1} state_t;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
  localparam int CNT_W = 16;
endpackage

// File: rtl/regs_rr_pick.sv
// regs_rr_pick: 2-way round-robin grant; pref names the requester that wins a tie
module regs_rr_pick
  import regs_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       pref,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] && (!valid[1] || pref == REQ0);
  assign grant[1] = valid[1] && (!valid[0] || pref == REQ1);
endmodule

// File: rtl/regs_wr_arb.sv
// regs_wr_arb: round-robin write arbiter with per-requester lock for the regs write port
// Optional write counter on o_wr_cnt when REGS_WR_ARB_CNT_EN is defined.
module regs_wr_arb
  import regs_pkg::*;
#(
  parameter int REGS_WIDTH      = 8,
  parameter int REGS_WIDTH_ADDR = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_req0_valid,
  input  logic [REGS_WIDTH_ADDR-1:0] i_req0_addr,
  input  logic [REGS_WIDTH-1:0]      i_req0_data,
  input  logic                       i_req0_lock,
  input  logic                       i_req1_valid,
  input  logic [REGS_WIDTH_ADDR-1:0] i_req1_addr,
  input  logic [REGS_WIDTH-1:0]      i_req1_data,
  input  logic                       i_req1_lock,
  output logic                       o_req0_ready,
  output logic                       o_req1_ready,
  output logic                       o_wt_en,
  output logic [REGS_WIDTH_ADDR-1:0] o_data_addr,
  output logic [REGS_WIDTH-1:0]      o_data,
  output logic [1:0]                 o_owner
`ifdef REGS_WR_ARB_CNT_EN
  ,output logic [CNT_W-1:0]          o_wr_cnt
`endif
);
  state_t     state, state_n;
  logic       last;
  logic [1:0] pick, rdy;
  logic       xfer, sel, lock_sel;
  regs_rr_pick u_pick (
    .valid ({i_req1_valid, i_req0_valid}),
    .pref  (~last),
    .grant (pick)
  );
  always_comb begin
    rdy = !i_rst_n ? 2'b00 :
          state == S_OWN0 ? {1'b0, i_req0_valid} :
          state == S_OWN1 ? {i_req1_valid, 1'b0} : pick;
    xfer = |rdy;
    sel = rdy[1];
    lock_sel = sel ? i_req1_lock : i_req0_lock;
    state_n = !xfer ? state : !lock_sel ? S_IDLE : sel ? S_OWN1 : S_OWN0;
  end
  assign o_req0_ready = rdy[0];
  assign o_req1_ready = rdy[1];
  assign o_owner = {state != S_IDLE, state == S_OWN1};
  // last starts at REQ1 so requester 0 wins the first tie after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      last <= REQ1;
      o_wt_en <= 1'b0;
      o_data_addr <= '0;
      o_data <= '0;
    end else begin
      state <= state_n;
      o_wt_en <= xfer;
      if (xfer) begin
        last <= sel;
        o_data_addr <= sel ? i_req1_addr : i_req0_addr;
        o_data <= sel ? i_req1_data : i_req0_data;
      end
    end
  end
`ifdef REGS_WR_ARB_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else if (o_wt_en) cnt <= cnt + 1'b1;
  end
  assign o_wr_cnt = cnt;
`endif
endmodule

// File: tb/tb_regs_wr_arb.sv
// tb_regs_wr_arb: table vectors, directed corner sequences and random traffic against a behavioural model
module tb_regs_wr_arb;
  logic       i_clk = 1'b0, i_rst_n = 1'b0;
  logic       i_req0_valid = 1'b1, i_req0_lock = 1'b0, i_req1_valid = 1'b1, i_req1_lock = 1'b0;
  logic [3:0] i_req0_addr = '0, i_req1_addr = '0;
  logic [7:0] i_req0_data = '0, i_req1_data = '0;
  logic       o_req0_ready, o_req1_ready, o_wt_en;
  logic [3:0] o_data_addr;
  logic [7:0] o_data;
  logic [1:0] o_owner;
`ifdef REGS_WR_ARB_CNT_EN
  logic [15:0] o_wr_cnt;
`endif
  regs_wr_arb #(.REGS_WIDTH(8), .REGS_WIDTH_ADDR(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .i_req0_addr(i_req0_addr), .i_req0_data(i_req0_data), .i_req0_lock(i_req0_lock),
    .i_req1_valid(i_req1_valid), .i_req1_addr(i_req1_addr), .i_req1_data(i_req1_data), .i_req1_lock(i_req1_lock),
    .o_req0_ready(o_req0_ready), .o_req1_ready(o_req1_ready),
    .o_wt_en(o_wt_en), .o_data_addr(o_data_addr), .o_data(o_data), .o_owner(o_owner)
`ifdef REGS_WR_ARB_CNT_EN
    , .o_wr_cnt(o_wr_cnt)
`endif
  );
  always #5 i_clk = ~i_clk;

  logic [7:0] dmem [16];
  always @(posedge i_clk) if (o_wt_en) dmem[o_data_addr] <= o_data;

  int checks = 0, failures = 0;
  int mown;
  bit mlast;
  bit e_wt;
  logic [3:0] e_addr;
  logic [7:0] e_data;
  logic [15:0] mcnt;
  logic [7:0] mmem [16];
  bit mwr [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mgrant();
    if (!i_rst_n) return -1;
    if (mown >= 0) return ((mown == 0) ? i_req0_valid : i_req1_valid) ? mown : -1;
    if (i_req0_valid && i_req1_valid) return mlast ? 0 : 1;
    if (i_req0_valid) return 0;
    if (i_req1_valid) return 1;
    return -1;
  endfunction

  task automatic cyc(input logic v0, input logic [3:0] a0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [3:0] a1, input logic [7:0] d1, input logic l1,
                     output logic r0s, output logic r1s);
    int g;
    i_req0_valid = v0; i_req0_addr = a0; i_req0_data = d0; i_req0_lock = l0;
    i_req1_valid = v1; i_req1_addr = a1; i_req1_data = d1; i_req1_lock = l1;
    #2;
    g = mgrant();
    r0s = o_req0_ready;
    r1s = o_req1_ready;
    chk("ready0", o_req0_ready, g == 0);
    chk("ready1", o_req1_ready, g == 1);
    @(posedge i_clk);
    if (e_wt) begin
      mcnt++;
      mmem[e_addr] = e_data;
      mwr[e_addr] = 1'b1;
    end
    e_wt = (g >= 0);
    if (g >= 0) begin
      mlast = g[0];
      mown = ((g == 0) ? l0 : l1) ? g : -1;
      e_addr = (g == 0) ? a0 : a1;
      e_data = (g == 0) ? d0 : d1;
    end
    #1;
    chk("wt_en", o_wt_en, e_wt);
    chk("addr", o_data_addr, e_addr);
    chk("data", o_data, e_data);
    chk("owner", o_owner, mown < 0 ? 2'b00 : (mown == 0 ? 2'b10 : 2'b11));
`ifdef REGS_WR_ARB_CNT_EN
    chk("wr_cnt", o_wr_cnt, mcnt);
`endif
  endtask

  task automatic do_reset();
    i_req0_valid = 1'b1; i_req1_valid = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("rst_ready0", o_req0_ready, 0);
    chk("rst_ready1", o_req1_ready, 0);
    chk("rst_wt_en", o_wt_en, 0);
    chk("rst_owner", o_owner, 0);
    chk("rst_addr", o_data_addr, 0);
    chk("rst_data", o_data, 0);
`ifdef REGS_WR_ARB_CNT_EN
    chk("rst_cnt", o_wr_cnt, 0);
`endif
    mown = -1; mlast = 1'b1; e_wt = 1'b0; e_addr = '0; e_data = '0; mcnt = '0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  typedef struct {logic v0, l0, v1, l1, r0, r1; logic [1:0] own;} vec_t;
  vec_t tbl [13];

  initial begin
    logic r0s, r1s;
    tbl[0]  = '{1,0,1,0, 1,0, 2'b00};
    tbl[1]  = '{1,0,1,0, 0,1, 2'b00};
    tbl[2]  = '{1,1,1,0, 1,0, 2'b00};
    tbl[3]  = '{1,1,1,0, 1,0, 2'b10};
    tbl[4]  = '{0,0,1,0, 0,0, 2'b10};
    tbl[5]  = '{1,0,1,0, 1,0, 2'b10};
    tbl[6]  = '{1,0,1,0, 0,1, 2'b00};
    tbl[7]  = '{0,0,1,1, 0,1, 2'b00};
    tbl[8]  = '{1,0,0,0, 0,0, 2'b11};
    tbl[9]  = '{1,0,1,0, 0,1, 2'b11};
    tbl[10] = '{0,0,0,0, 0,0, 2'b00};
    tbl[11] = '{0,0,1,0, 0,1, 2'b00};
    tbl[12] = '{1,0,1,0, 1,0, 2'b00};
    for (int i = 0; i < 16; i++) mwr[i] = 1'b0;
    @(posedge i_clk);
    #1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_owner", i), o_owner, tbl[i].own);
      cyc(tbl[i].v0, 4'(i), 8'(8'h10 + i), tbl[i].l0, tbl[i].v1, 4'(i + 8), 8'(8'h80 + i), tbl[i].l1, r0s, r1s);
      chk($sformatf("tbl%0d_r0", i), r0s, tbl[i].r0);
      chk($sformatf("tbl%0d_r1", i), r1s, tbl[i].r1);
    end
    // contention: strict alternation from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 4'd1, 8'hA0, 0, 1, 4'd2, 8'hB0, 0, r0s, r1s);
      chk("cont_r1", r1s, i % 2);
      chk("cont_r0", r0s, (i + 1) % 2);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
    chk("cont_mem1", dmem[1], 8'hA0);
    chk("cont_mem2", dmem[2], 8'hB0);
    // lock by req1 across three beats while req0 waits
    cyc(1, 4'd9, 8'h01, 0, 0, 0, 0, 0, r0s, r1s);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) chk("lock_owner", o_owner, 2'b11);
      cyc(1, 4'd9, 8'h02, 0, 1, 4'(4 + i), 8'(8'hC0 + i), i < 2, r0s, r1s);
      chk("lock_r0", r0s, 0);
      chk("lock_r1", r1s, 1);
    end
    cyc(1, 4'd9, 8'h03, 0, 1, 4'd7, 8'hCC, 0, r0s, r1s);
    chk("lock_after_r0", r0s, 1);
    // owner goes quiet for five cycles
    cyc(1, 4'd3, 8'h33, 1, 0, 0, 0, 0, r0s, r1s);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1, 4'd8, 8'h88, 0, r0s, r1s);
      chk("idle_r1", r1s, 0);
      chk("idle_wt", o_wt_en, 0);
    end
    cyc(1, 4'd3, 8'h34, 0, 1, 4'd8, 8'h88, 0, r0s, r1s);
    chk("idle_release_r0", r0s, 1);
    // reset while req0 owns the port
    cyc(1, 4'd5, 8'h55, 1, 0, 0, 0, 0, r0s, r1s);
    chk("midlock_owner", o_owner, 2'b10);
    do_reset();
    cyc(0, 0, 0, 0, 1, 4'd6, 8'h66, 0, r0s, r1s);
    chk("midlock_r1", r1s, 1);
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) != 0, 4'($urandom), 8'($urandom), $urandom_range(0, 2) == 0, r0s, r1s);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
    for (int i = 0; i < 16; i++) if (mwr[i]) chk($sformatf("mem%0d", i), dmem[i], mmem[i]);
`ifdef REGS_WR_ARB_CNT_EN
    do_reset();
    for (int i = 0; i < 65537; i++) cyc(1, 4'd0, 8'h5A, 0, 0, 0, 0, 0, r0s, r1s);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, r0s, r1s);
    chk("cnt_wrap", o_wr_cnt, 16'd1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regs_wr_arb.md
# regs_wr_arb

Two-requester write-port arbiter for the `regs` register file (REGS_WIDTH × 2^REGS_WIDTH_ADDR), placed between two producers and the single `regs` write port. Accepts writes via valid/ready handshakes, selects one per cycle by round-robin with an optional per-requester lock for atomic multi-register updates, and drives the register file write port from registered outputs. The `regs` read port is not touched.

## Interface
Parameters:
- REGS_WIDTH, 8, data width; must match `regs`.
- REGS_WIDTH_ADDR, 4, address width; must match `regs`.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req0_valid / i_req1_valid  in  1  requester n has a write pending.
- i_req0_addr / i_req1_addr  in  REGS_WIDTH_ADDR  target register.
- i_req0_data / i_req1_data  in  REGS_WIDTH  write data.
- i_req0_lock / i_req1_lock  in  1  hold ownership after this beat.
- o_req0_ready / o_req1_ready  out  1  beat accepted this cycle (combinational).
- o_wt_en  out  1  to `regs` i_wt_en.
- o_data_addr  out  REGS_WIDTH_ADDR  to `regs` i_data_addr.
- o_data  out  REGS_WIDTH  to `regs` i_data.
- o_owner  out  2  {locked, owner id}; 2'b00 when unlocked.
- o_wr_cnt  out  16  writes issued (only with REGS_WR_ARB_CNT_EN).

## Operation
- Transfer on requester n = i_reqn_valid && o_reqn_ready. At most one ready high per cycle.
- FSM states: S_IDLE, S_OWN0, S_OWN1.
- S_IDLE: one valid → grant it. Both valid → grant the requester NOT granted last (rr pointer). rr pointer updates on every transfer; reset value favours requester 0.
- Accepted beat with lock=1 → S_OWNn (n = granted). Lock=0 → stay/return S_IDLE.
- S_OWNn: only requester n may be granted (ready = i_reqn_valid); other requester stalls regardless of valid. Beat with lock=0 → S_IDLE. Owner deasserting valid keeps S_OWNn (no timeout).
- Ready never depends on the other requester's ready; ready may depend on own valid.
- Accepted beat registered into o_data_addr/o_data with o_wt_en=1 next cycle; o_wt_en=0 in cycles with no transfer (addr/data hold last value).
- Same-address writes from both requesters in consecutive cycles: issued in grant order; last write wins in `regs`.

## Timing
- Reset (async assert, sync release): FSM=S_IDLE, rr pointer → requester 0 preferred, o_wt_en=0, o_data_addr=0, o_data=0, o_owner=0, o_wr_cnt=0. Readys are 0 during reset.
- Latency: handshake in cycle T → o_wt_en=1 in T+1 → `regs` updated at end of T+1.
- Throughput: one write per cycle sustained.
- Reset mid-lock: ownership dropped; pending beats not written.
- o_owner reflects FSM state registered (updates cycle after locking beat).

## Configuration
- REGS_WR_ARB_CNT_EN defined: o_wr_cnt port present; increments by 1 on every cycle o_wt_en=1; wraps 16'hFFFF → 16'h0000; reset 0.
- Not defined: o_wr_cnt port and counter absent; all other behaviour identical.

## Structure
- Shared package regs_pkg: state enum (S_IDLE, S_OWN0, S_OWN1), requester-id constants REQ0=1'b0/REQ1=1'b1, counter width constant 16.
- One sub-module natural: regs_rr_pick (2-way round-robin grant from valid vector + pointer, combinational). Registers and FSM stay in regs_wr_arb.

## Test plan
- Reset: hold i_rst_n=0 with both valids high → all readys 0, o_wt_en=0, o_owner=0; release → first cycle grants req0.
- Contention: both valid every cycle, lock=0, req0 addr 1 data 8'hA0, req1 addr 2 data 8'hB0 → grants alternate 0,1,0,1; o_wt_en=1 each cycle from T+1; `regs`[1]=8'hA0, [2]=8'hB0.
- Lock: req1 sends 3 beats addr 4,5,6 with lock=1,1,0 while req0 valid → req0 ready=0 for all 3; o_owner=2'b11 during; then req0 granted.
- Owner idle: req0 locks, drops valid 5 cycles while req1 valid → req1 ready stays 0, o_wt_en=0 for those cycles.
- Reset mid-lock: assert i_rst_n=0 in S_OWN0 → o_owner=0, FSM S_IDLE; req1 granted first cycle after release if only req1 valid.
- Counter (macro on): 65537 single writes → o_wr_cnt reads 1 after wrap.
